// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the data-memory readback engine.
//   state_t     : FSM state encoding (IDLE=0, RD=1, CAP=2, SEND=3, FIN=4)
//   WORD_STRIDE : byte distance between consecutive memory words
package mem_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a word range of the CPU data memory through a
// dedicated synchronous read port and streams every word out on a
// valid/ready interface together with its byte address, a last flag and a
// running mod-2^DATA_WIDTH checksum.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset
//   start      : begin a dump (sampled only while idle)
//   base_addr  : byte address of first word, low two bits ignored
//   word_count : number of words to dump (0 allowed)
//   busy       : high whenever not idle
//   done       : one-cycle pulse when a dump completes
//   mem_rd_en  : read strobe to data memory
//   mem_addr   : byte address presented with mem_rd_en
//   mem_rdata  : read data, valid the cycle after mem_rd_en
//   out_valid  : out_data / out_addr / out_last are valid
//   out_ready  : consumer accepts the word on out_valid && out_ready
//   out_data   : memory word
//   out_addr   : byte address of out_data
//   out_last   : final word of the dump
//   checksum   : sum of all words transferred in the current/last dump
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [31:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           out_addr,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] checksum
);

    state_t                state_reg;
    state_t                state_next;

    logic [31:0]           addr_reg;
    logic [CNT_WIDTH-1:0]  remaining_reg;
    logic [DATA_WIDTH-1:0] checksum_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [31:0]           out_addr_reg;
    logic                  out_last_reg;

    // Datapath strobes decoded by the FSM
    logic                  start_accept;
    logic                  capture;
    logic                  transfer;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        busy         = 1'b1;
        done         = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        out_valid    = 1'b0;
        start_accept = 1'b0;
        capture      = 1'b0;
        transfer     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_accept = 1'b1;
                    // A zero-length dump skips the memory entirely
                    state_next   = (word_count == '0) ? ST_FIN : ST_RD;
                end
            end
            ST_RD: begin
                mem_rd_en  = 1'b1;
                mem_addr   = addr_reg;
                state_next = ST_CAP;
            end
            ST_CAP: begin
                capture    = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    transfer   = 1'b1;
                    state_next = out_last_reg ? ST_FIN : ST_RD;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / remaining counters, output holding registers, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            checksum_reg  <= '0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (start_accept) begin
                // Word-align by masking off the byte-offset bits
                addr_reg      <= base_addr & ~(WORD_STRIDE - 32'd1);
                remaining_reg <= word_count;
                checksum_reg  <= '0;
            end
            if (capture) begin
                out_data_reg <= mem_rdata;
                out_addr_reg <= addr_reg;
                out_last_reg <= (remaining_reg == CNT_WIDTH'(1));
            end
            if (transfer) begin
                checksum_reg  <= checksum_reg + out_data_reg;
                // remaining never underflows: the last word exits to FIN
                remaining_reg <= remaining_reg - CNT_WIDTH'(1);
                // Wraps mod 2^32 without any error indication
                addr_reg      <= addr_reg + WORD_STRIDE;
            end
        end
    end

    assign out_data = out_data_reg;
    assign out_addr = out_addr_reg;
    assign out_last = out_last_reg;
    assign checksum = checksum_reg;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: a 1024-word synchronous memory
// model feeds the read port; each dump's expected word stream and checksum
// are computed up front from the memory contents and compared cycle by cycle.
module tb_mem_dump_reader;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   base_addr;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_addr;
    logic          out_last;
    logic [DW-1:0] checksum;

    logic [31:0]   mem [0:1023];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_dump_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .checksum   (checksum)
    );

    // 1-cycle synchronous read memory; address wraps within 4 KiB
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[11:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One dump. stall_word: 0-based word held off for 5 cycles (-1 none).
    // poke_start: pulse start with junk while reading. abort_word: 1-based
    // word during whose SEND reset is asserted (0 none).
    task automatic run_dump(input logic [31:0] base, input int count, input int ready_pct,
                            input int stall_word, input bit poke_start, input int abort_word);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] aligned;
        logic [31:0] a;
        logic [31:0] model_sum;
        int  n, sent, reads, stall_left, last_xfer_n, budget;
        bit  done_seen, valid_seen, ready_now;

        aligned   = base & 32'hFFFF_FFFC;
        model_sum = '0;
        for (int k = 0; k < count; k++) begin
            a = aligned + 32'(4 * k);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a[11:2]]);
        end
        n = 0; sent = 0; reads = 0; stall_left = 5; last_xfer_n = -10;
        budget = 100 + count * 60;
        done_seen = 1'b0; valid_seen = 1'b0;

        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = CW'(count);
        out_ready  = 1'b0;

        while (!done_seen && n < budget) begin
            @(negedge clk);
            n++;
            if (poke_start && mem_rd_en && n > 1) begin
                start      = 1'b1;
                base_addr  = $urandom;
                word_count = CW'($urandom_range(1, 50));
            end else begin
                start      = 1'b0;
                base_addr  = $urandom;
                word_count = CW'($urandom);
            end

            check_eq("busy", 32'(busy), 32'd1);
            check_eq("checksum", checksum, model_sum);

            if (mem_rd_en) begin
                if (reads < count) check_eq("rd_addr", mem_addr, exp_addr[reads]);
                else               check_eq("extra_rd", 32'(reads), 32'(count));
                if (reads == 0)    check_eq("rd_latency", 32'(n), 32'd1);
                check_eq("rd_during_send", 32'(out_valid), 32'd0);
                reads++;
            end

            if (out_valid) begin
                if (sent < count) begin
                    check_eq("out_data", out_data, exp_data[sent]);
                    check_eq("out_addr", out_addr, exp_addr[sent]);
                    check_eq("out_last", 32'(out_last), 32'(sent == count - 1));
                end else begin
                    check_eq("extra_valid", 32'(sent), 32'(count));
                end
                if (!valid_seen) begin
                    check_eq("valid_latency", 32'(n), 32'd3);
                    valid_seen = 1'b1;
                end
                if (abort_word > 0 && sent == abort_word - 1) begin
                    reset = 1'b0;
                    start = 1'b0;
                    @(negedge clk);
                    check_eq("abort_busy", 32'(busy), 32'd0);
                    check_eq("abort_valid", 32'(out_valid), 32'd0);
                    check_eq("abort_checksum", checksum, 32'd0);
                    check_eq("abort_done", 32'(done), 32'd0);
                    check_eq("abort_rd_en", 32'(mem_rd_en), 32'd0);
                    check_eq("abort_out_data", out_data, 32'd0);
                    check_eq("abort_out_addr", out_addr, 32'd0);
                    check_eq("abort_out_last", 32'(out_last), 32'd0);
                    $display("dump base=%h count=%0d aborted at word %0d", base, count, abort_word);
                    reset = 1'b1;
                    out_ready = 1'b0;
                    @(negedge clk);
                    check_eq("post_abort_idle", 32'(busy), 32'd0);
                    return;
                end
                if (stall_word == sent && stall_left > 0) begin
                    ready_now = 1'b0;
                    stall_left--;
                end else begin
                    ready_now = ($urandom_range(99) < 32'(ready_pct));
                end
            end else begin
                ready_now = 1'($urandom_range(1));
            end
            out_ready = ready_now;
            if (out_valid && ready_now && sent < count) begin
                model_sum += exp_data[sent];
                sent++;
                last_xfer_n = n;
            end

            if (done) begin
                done_seen = 1'b1;
                if (count == 0) check_eq("done_latency", 32'(n), 32'd1);
                else            check_eq("done_latency", 32'(n), 32'(last_xfer_n + 1));
                check_eq("words_sent", 32'(sent), 32'(count));
                check_eq("words_read", 32'(reads), 32'(count));
            end
        end

        check_eq("done_seen", 32'(done_seen), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("final_checksum", checksum, model_sum);
        $display("dump base=%h count=%0d cycles=%0d checksum=%h", base, count, n, checksum);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[64] = 32'h1111_1111;
        mem[65] = 32'h2222_2222;
        mem[66] = 32'h3333_3333;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_out_addr", out_addr, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_checksum", checksum, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_dump(32'h0000_0100, 3, 100, -1, 1'b0, 0);
        check_eq("sum_basic", checksum, 32'h6666_6666);
        run_dump(32'h0000_0100, 3, 100, 1, 1'b0, 0);
        check_eq("sum_stall", checksum, 32'h6666_6666);
        run_dump(32'h0000_0037, 0, 100, -1, 1'b0, 0);
        check_eq("sum_empty", checksum, 32'd0);
        run_dump(32'hFFFF_FFFE, 2, 100, -1, 1'b0, 0);
        run_dump(32'h0000_0100, 3, 100, -1, 1'b0, 2);
        run_dump(32'h0000_0100, 3, 100, -1, 1'b0, 0);
        check_eq("sum_after_abort", checksum, 32'h6666_6666);
        run_dump(32'h0000_0200, 4, 100, -1, 1'b1, 0);

        for (int r = 0; r < 10; r++) begin
            run_dump($urandom, $urandom_range(0, 12), $urandom_range(30, 100),
                     $urandom_range(0, 4) - 1, 1'($urandom_range(1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
